// File: rtl/mouse_packet_decoder_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// Header bit positions follow the standard PS/2 mouse first byte.
package mouse_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_X,
        S_Y,
        S_Z
    } state_t;

    localparam int BTN_L    = 0;
    localparam int BTN_R    = 1;
    localparam int BTN_M    = 2;
    localparam int SYNC_BIT = 3;
    localparam int SGN_X    = 4;
    localparam int SGN_Y    = 5;
    localparam int OVF_X    = 6;
    localparam int OVF_Y    = 7;

    localparam int DELTA_MAX = 255;
    localparam int DELTA_MIN = -256;

    // An overflowed axis reports the extreme value in the direction of its sign.
    function automatic logic signed [8:0] sat_delta(input logic sgn, input logic ovf,
                                                    input logic [7:0] mag);
        if (ovf)
            return sgn ? 9'(DELTA_MIN) : 9'(DELTA_MAX);
        return $signed({sgn, mag});
    endfunction

endpackage

// File: rtl/mouse_packet_decoder_if.sv
// Byte input and decoded-packet outputs of the mouse decoder.
// The slave side is the decoder; the master side is the receiver/consumer.
interface mouse_packet_decoder_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic               byte_strb;
    logic [7:0]         byte_data;
    logic               pkt_valid;
    logic signed [8:0]  dx;
    logic signed [8:0]  dy;
    logic signed [3:0]  dz;
    logic [2:0]         btn;
    logic [2:0]         btn_press;
    logic [2:0]         btn_release;
    logic [X_W-1:0]     cursor_x;
    logic [Y_W-1:0]     cursor_y;
    logic               sync_err;
    logic               busy;

    modport master (
        output byte_strb, byte_data,
        input  pkt_valid, dx, dy, dz, btn, btn_press, btn_release,
               cursor_x, cursor_y, sync_err, busy
    );

    modport slave (
        input  byte_strb, byte_data,
        output pkt_valid, dx, dy, dz, btn, btn_press, btn_release,
               cursor_x, cursor_y, sync_err, busy
    );
endinterface

// File: rtl/mouse_packet_decoder_axis_accum.sv
// One cursor axis: shifted signed delta added (or subtracted) and clamped to 0..LIMIT.
// Position registers one cycle after en_i; no backpressure.
module mouse_axis_accum #(
    parameter int W         = 10,
    parameter int LIMIT     = 639,
    parameter int RESET_VAL = 320,
    parameter int SHIFT     = 0,
    parameter bit NEGATE    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic signed [8:0] delta_i,
    output logic [W-1:0]      pos_o
);
    // Wide enough for position plus any shifted delta, so the sum never wraps.
    localparam int AW = ((W > 9) ? W : 9) + SHIFT + 2;
    localparam logic signed [AW-1:0] LIM_S = AW'(LIMIT);

    logic [W-1:0]         pos_q, pos_d;
    logic signed [AW-1:0] step, base, sum;

    always_comb begin
        step  = $signed({{(AW-9){delta_i[8]}}, delta_i}) <<< SHIFT;
        base  = $signed({{(AW-W){1'b0}}, pos_q});
        sum   = NEGATE ? (base - step) : (base + step);
        pos_d = pos_q;
        if (en_i) begin
            if (sum < 0)
                pos_d = '0;
            else if (sum > LIM_S)
                pos_d = W'(LIMIT);
            else
                pos_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pos_q <= W'(RESET_VAL);
        else
            pos_q <= pos_d;
    end

    assign pos_o = pos_q;
endmodule

// File: rtl/mouse_packet_decoder.sv
// Frames 3/4-byte PS/2 mouse packets into deltas, button edges and a clamped cursor.
// Outputs register one cycle after the final byte is accepted; no backpressure.
module mouse_packet_decoder
    import mouse_pkg::*;
#(
    parameter int PKT_BYTES   = 3,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int SPEED_SHIFT = 0
) (
    input logic              clk,
    input logic              rst,
    mouse_packet_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_t            state_q;
    logic [2:0]        strb_q;      // [1:0] synchroniser, [2] previous synchronised level
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        hbtn_q;
    logic              sgn_x_q, sgn_y_q, ovf_x_q, ovf_y_q;
    logic [7:0]        x_q, y_q;
    logic              pkt_valid_q, sync_err_q;
    logic signed [8:0] dx_q, dy_q;
    logic signed [3:0] dz_q;
    logic [2:0]        btn_q, press_q, release_q;

    logic              accept, timeout, last_byte;
    logic [7:0]        y_byte;
    logic signed [8:0] new_dx, new_dy;
    logic signed [3:0] new_dz;

    always_comb begin
        accept    = strb_q[1] & ~strb_q[2];
        timeout   = (state_q != S_HDR) && !accept && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        last_byte = accept && (state_q == ((PKT_BYTES == 4) ? S_Z : S_Y));
        // In 4-byte mode the Y byte is already latched when the wheel byte arrives.
        y_byte    = (PKT_BYTES == 4) ? y_q : bus.byte_data;
        new_dx    = sat_delta(sgn_x_q, ovf_x_q, x_q);
        new_dy    = sat_delta(sgn_y_q, ovf_y_q, y_byte);
        new_dz    = (PKT_BYTES == 4) ? $signed(bus.byte_data[3:0]) : 4'sd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HDR;
            strb_q      <= '0;
            cnt_q       <= '0;
            hbtn_q      <= '0;
            sgn_x_q     <= 1'b0;
            sgn_y_q     <= 1'b0;
            ovf_x_q     <= 1'b0;
            ovf_y_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            dz_q        <= '0;
            btn_q       <= '0;
            press_q     <= '0;
            release_q   <= '0;
        end else begin
            strb_q      <= {strb_q[1:0], bus.byte_strb};
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            press_q     <= '0;
            release_q   <= '0;
            cnt_q       <= (accept || state_q == S_HDR) ? '0 : cnt_q + 1'b1;

            case (state_q)
                S_HDR: if (accept) begin
                    if (bus.byte_data[SYNC_BIT]) begin
                        hbtn_q  <= bus.byte_data[BTN_M:BTN_L];
                        sgn_x_q <= bus.byte_data[SGN_X];
                        sgn_y_q <= bus.byte_data[SGN_Y];
                        ovf_x_q <= bus.byte_data[OVF_X];
                        ovf_y_q <= bus.byte_data[OVF_Y];
                        state_q <= S_X;
                    end else begin
                        sync_err_q <= 1'b1;
                    end
                end
                S_X: if (accept) begin
                    x_q     <= bus.byte_data;
                    state_q <= S_Y;
                end else if (timeout) begin
                    state_q    <= S_HDR;
                    sync_err_q <= 1'b1;
                end
                S_Y: if (accept) begin
                    y_q     <= bus.byte_data;
                    state_q <= (PKT_BYTES == 4) ? S_Z : S_HDR;
                end else if (timeout) begin
                    state_q    <= S_HDR;
                    sync_err_q <= 1'b1;
                end
                default: if (accept) begin
                    state_q <= S_HDR;
                end else if (timeout) begin
                    state_q    <= S_HDR;
                    sync_err_q <= 1'b1;
                end
            endcase

            if (last_byte) begin
                pkt_valid_q <= 1'b1;
                dx_q        <= new_dx;
                dy_q        <= new_dy;
                dz_q        <= new_dz;
                btn_q       <= hbtn_q;
                press_q     <= hbtn_q & ~btn_q;
                release_q   <= ~hbtn_q & btn_q;
            end
        end
    end

    mouse_axis_accum #(
        .W(X_W), .LIMIT(SCREEN_W - 1), .RESET_VAL(SCREEN_W / 2),
        .SHIFT(SPEED_SHIFT), .NEGATE(1'b0)
    ) u_acc_x (
        .clk(clk), .rst(rst), .en_i(last_byte), .delta_i(new_dx), .pos_o(bus.cursor_x)
    );

    // PS/2 y is positive-up while the screen grows downward.
    mouse_axis_accum #(
        .W(Y_W), .LIMIT(SCREEN_H - 1), .RESET_VAL(SCREEN_H / 2),
        .SHIFT(SPEED_SHIFT), .NEGATE(1'b1)
    ) u_acc_y (
        .clk(clk), .rst(rst), .en_i(last_byte), .delta_i(new_dy), .pos_o(bus.cursor_y)
    );

    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.dx          = dx_q;
    assign bus.dy          = dy_q;
    assign bus.dz          = dz_q;
    assign bus.btn         = btn_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.busy        = (state_q != S_HDR);
endmodule
